// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register.
//
// Contents: RegDst select encodings, control-word field layout (24 bits, MSB first:
// RegDst, NPCFrom, MemRead, MemToReg, ALUOp, ALUExtOp, MemWrite, ALUSrc1, ALUSrc2,
// RegWrite, ImmExtend, funct-derived ALU op), the all-zero bubble word, and field
// extraction helpers used by the hazard unit.
package id_ex_pipe_pkg;

  localparam int unsigned CTRLW = 24;

  // Field widths, MSB to LSB. The named fields leave 2 bits for the funct-derived
  // ALU op so the whole word stays at 24 bits.
  localparam int unsigned CTRLW_REGDST_W    = 2;
  localparam int unsigned CTRLW_NPCFROM_W   = 2;
  localparam int unsigned CTRLW_MEMTOREG_W  = 2;
  localparam int unsigned CTRLW_ALUOP_W     = 3;
  localparam int unsigned CTRLW_ALUEXTOP_W  = 5;
  localparam int unsigned CTRLW_ALUSRC1_W   = 2;
  localparam int unsigned CTRLW_ALUSRC2_W   = 2;
  localparam int unsigned CTRLW_FUNCTOP_W   = 2;

  // Field LSB offsets.
  localparam int unsigned CTRLW_REGDST_LSB    = 22;
  localparam int unsigned CTRLW_NPCFROM_LSB   = 20;
  localparam int unsigned CTRLW_MEMREAD_LSB   = 19;
  localparam int unsigned CTRLW_MEMTOREG_LSB  = 17;
  localparam int unsigned CTRLW_ALUOP_LSB     = 14;
  localparam int unsigned CTRLW_ALUEXTOP_LSB  = 9;
  localparam int unsigned CTRLW_MEMWRITE_LSB  = 8;
  localparam int unsigned CTRLW_ALUSRC1_LSB   = 6;
  localparam int unsigned CTRLW_ALUSRC2_LSB   = 4;
  localparam int unsigned CTRLW_REGWRITE_LSB  = 3;
  localparam int unsigned CTRLW_IMMEXTEND_LSB = 2;
  localparam int unsigned CTRLW_FUNCTOP_LSB   = 0;

  // RegDst encodings; the fourth code selects no destination.
  localparam logic [1:0] SEL_REGDST_RT = 2'd0;
  localparam logic [1:0] SEL_REGDST_RD = 2'd1;
  localparam logic [1:0] SEL_REGDST_RA = 2'd2;

  // A bubble clears RegWrite, MemWrite, MemRead and NPCFrom along with everything else.
  localparam logic [CTRLW-1:0] CTRL_BUBBLE = '0;

  function automatic logic [1:0] ctrl_regdst(input logic [CTRLW-1:0] c);
    return c[CTRLW_REGDST_LSB +: CTRLW_REGDST_W];
  endfunction

  function automatic logic ctrl_memread(input logic [CTRLW-1:0] c);
    return c[CTRLW_MEMREAD_LSB];
  endfunction

  function automatic logic ctrl_regwrite(input logic [CTRLW-1:0] c);
    return c[CTRLW_REGWRITE_LSB];
  endfunction

endpackage

// File: rtl/id_ex_pipe_hazard.sv
// Combinational hazard unit for the ID/EX register.
//
// Ports:
//   ex_valid, ex_ctrl, ex_rt, ex_rd  : instruction currently held in EX
//   id_valid, id_rs, id_rt, id_use_* : instruction waiting in ID
//   ex_stall, flush                  : EX back-pressure and branch/jump kill
//   ex_dst                           : write-back destination of the EX instruction
//   hz_loaduse                       : load-use bubble is inserted this cycle
//   hz_stall                         : PC and IF/ID must hold this cycle
module id_ex_pipe_hazard
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned RW = 5
) (
  input  logic             ex_valid,
  input  logic [CTRLW-1:0] ex_ctrl,
  input  logic [RW-1:0]    ex_rt,
  input  logic [RW-1:0]    ex_rd,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_stall,
  input  logic             flush,
  output logic [RW-1:0]    ex_dst,
  output logic             hz_loaduse,
  output logic             hz_stall
);

  logic src_match;
  logic load_use;

  always_comb begin
    ex_dst = '0;
    case (ctrl_regdst(ex_ctrl))
      SEL_REGDST_RT: ex_dst = ex_rt;
      SEL_REGDST_RD: ex_dst = ex_rd;
      SEL_REGDST_RA: ex_dst = RW'(31);
      default:       ex_dst = '0;
    endcase
  end

  always_comb begin
    src_match  = (id_use_rs && (id_rs == ex_dst)) || (id_use_rt && (id_rt == ex_dst));
    // $0 is never a real destination, so a load into it cannot create a hazard.
    load_use   = ex_valid && ctrl_memread(ex_ctrl) && ctrl_regwrite(ex_ctrl) &&
                 (ex_dst != '0) && id_valid && src_match;
    // A flush kills the ID instruction, so neither the bubble nor the hold is needed.
    hz_loaduse = load_use && !flush;
    hz_stall   = hz_loaduse || (ex_stall && !flush);
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, EX hold and flush.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   id_*              : decoded instruction from the ID stage
//   ex_stall          : EX/MEM cannot accept a new instruction (hold everything)
//   flush             : taken branch/jump; replace the ID instruction with a bubble
//   ex_*              : registered instruction presented to EX
//   ex_dst            : combinational write-back destination of the EX instruction
//   hz_stall          : upstream PC and IF/ID must hold this cycle
//   hz_loaduse        : a load-use bubble is being inserted this cycle
//   bubble_cnt        : present only with IDEX_BUBBLE_CNT_EN; counts bubbles that
//                       displaced a valid ID instruction
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [CTRLW-1:0] id_ctrl,
  input  logic [DW-1:0]    id_pc4,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic [RW-1:0]    id_rd,
  input  logic [4:0]       id_shamt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [CTRLW-1:0] ex_ctrl,
  output logic [DW-1:0]    ex_pc4,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm,
  output logic [RW-1:0]    ex_rs,
  output logic [RW-1:0]    ex_rt,
  output logic [RW-1:0]    ex_rd,
  output logic [4:0]       ex_shamt,
  output logic [RW-1:0]    ex_dst,
  output logic             hz_stall,
  output logic             hz_loaduse
`ifdef IDEX_BUBBLE_CNT_EN
  ,
  output logic [31:0]      bubble_cnt
`endif
);

  id_ex_pipe_hazard #(
    .RW (RW)
  ) u_hazard (
    .ex_valid   (ex_valid),
    .ex_ctrl    (ex_ctrl),
    .ex_rt      (ex_rt),
    .ex_rd      (ex_rd),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .ex_stall   (ex_stall),
    .flush      (flush),
    .ex_dst     (ex_dst),
    .hz_loaduse (hz_loaduse),
    .hz_stall   (hz_stall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= CTRL_BUBBLE;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_shamt   <= '0;
    end else if (flush || (!ex_stall && hz_loaduse)) begin
      // Bubble: only valid and control are cleared, data fields hold.
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_BUBBLE;
    end else if (!ex_stall) begin
      ex_valid   <= id_valid;
      ex_ctrl    <= id_valid ? id_ctrl : CTRL_BUBBLE;
      ex_pc4     <= id_pc4;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_shamt   <= id_shamt;
    end
  end

`ifdef IDEX_BUBBLE_CNT_EN
  // The bubble displaces the ID instruction; count it only when that was real work.
  // hz_loaduse already implies id_valid and no flush.
  logic bubble_counted;
  assign bubble_counted = (flush && id_valid) || (!ex_stall && hz_loaduse);

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (bubble_counted) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;
  import id_ex_pipe_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, id_valid, id_use_rs, id_use_rt, ex_stall, flush;
  logic [23:0]      id_ctrl;
  logic [DW-1:0]    id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [RW-1:0]    id_rs, id_rt, id_rd;
  logic [4:0]       id_shamt;
  logic             ex_valid, hz_stall, hz_loaduse;
  logic [23:0]      ex_ctrl;
  logic [DW-1:0]    ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [RW-1:0]    ex_rs, ex_rt, ex_rd, ex_shamt, ex_dst;
  logic [31:0]      bubble_cnt_obs;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0]      bubble_cnt;
  assign bubble_cnt_obs = bubble_cnt;
`else
  assign bubble_cnt_obs = '0;
`endif

  id_ex_pipe #(.DW(DW), .RW(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_ctrl    (id_ctrl),
    .id_pc4     (id_pc4),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .id_imm     (id_imm),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_shamt   (id_shamt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .ex_stall   (ex_stall),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_ctrl    (ex_ctrl),
    .ex_pc4     (ex_pc4),
    .ex_rs_data (ex_rs_data),
    .ex_rt_data (ex_rt_data),
    .ex_imm     (ex_imm),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_rd      (ex_rd),
    .ex_shamt   (ex_shamt),
    .ex_dst     (ex_dst),
    .hz_stall   (hz_stall),
    .hz_loaduse (hz_loaduse)
`ifdef IDEX_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  typedef struct {
    bit          rst, valid, use_rs, use_rt, ex_stall, flush;
    logic [23:0] ctrl;
    logic [31:0] pc4, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd, shamt;
  } stim_t;

  typedef struct {
    logic        valid, stall, loaduse;
    logic [23:0] ctrl;
    logic [31:0] pc4, rs_data, rt_data, imm, cnt;
    logic [4:0]  rs, rt, rd, shamt, dst;
  } exp_t;

  // Reference model: the instruction the EX slot should hold, kept as a record.
  stim_t       m_ins;
  bit          m_valid;
  logic [31:0] m_cnt;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // Layout bits the model cares about: RegDst [23:22], MemRead [19], RegWrite [3].
  function automatic logic [23:0] mk_ctrl(input logic [1:0] regdst, input bit mr, input bit rw);
    logic [23:0] c;
    c = 24'($urandom);
    c[23:22] = regdst;
    c[19] = mr;
    c[3] = rw;
    return c;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.rst = 1'b0; s.ex_stall = 1'b0; s.flush = 1'b0;
    s.valid = 1'b1; s.use_rs = 1'b0; s.use_rt = 1'b0;
    s.ctrl = 24'($urandom);
    s.pc4 = $urandom; s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom;
    s.rs = 5'($urandom); s.rt = 5'($urandom); s.rd = 5'($urandom); s.shamt = 5'($urandom);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t        e;
    logic [4:0]  dst;
    bit          reads_dst, lu;
    rst = s.rst; id_valid = s.valid; id_ctrl = s.ctrl; id_pc4 = s.pc4;
    id_rs_data = s.rs_data; id_rt_data = s.rt_data; id_imm = s.imm;
    id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_shamt = s.shamt;
    id_use_rs = s.use_rs; id_use_rt = s.use_rt; ex_stall = s.ex_stall; flush = s.flush;
    // Destination register named by the EX instruction.
    if (m_ins.ctrl[23:22] == SEL_REGDST_RT)      dst = m_ins.rt;
    else if (m_ins.ctrl[23:22] == SEL_REGDST_RD) dst = m_ins.rd;
    else if (m_ins.ctrl[23:22] == SEL_REGDST_RA) dst = 5'd31;
    else                                         dst = 5'd0;
    reads_dst = (s.use_rs && s.rs == dst) || (s.use_rt && s.rt == dst);
    lu = m_valid && m_ins.ctrl[19] && m_ins.ctrl[3] && dst != 0 && s.valid && reads_dst
         && !s.flush;
    e.valid = m_valid; e.ctrl = m_ins.ctrl; e.pc4 = m_ins.pc4; e.rs_data = m_ins.rs_data;
    e.rt_data = m_ins.rt_data; e.imm = m_ins.imm; e.rs = m_ins.rs; e.rt = m_ins.rt;
    e.rd = m_ins.rd; e.shamt = m_ins.shamt; e.dst = dst; e.loaduse = lu;
    e.stall = lu || (s.ex_stall && !s.flush); e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    if (s.rst) begin
      m_ins = '{default: '0}; m_valid = 0; m_cnt = 0;
    end else if (s.flush || (!s.ex_stall && lu)) begin
      if (s.valid) m_cnt = m_cnt + 1;
      m_valid = 0; m_ins.ctrl = '0;
    end else if (!s.ex_stall) begin
      m_ins = s; m_valid = s.valid;
      if (!s.valid) m_ins.ctrl = '0;
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents its EX slot; compare against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cyc++;
      chk("ex_valid", 32'(ex_valid), 32'(e.valid));
      chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
      chk("ex_pc4", ex_pc4, e.pc4);
      chk("ex_rs_data", ex_rs_data, e.rs_data);
      chk("ex_rt_data", ex_rt_data, e.rt_data);
      chk("ex_imm", ex_imm, e.imm);
      chk("ex_rs", 32'(ex_rs), 32'(e.rs));
      chk("ex_rt", 32'(ex_rt), 32'(e.rt));
      chk("ex_rd", 32'(ex_rd), 32'(e.rd));
      chk("ex_shamt", 32'(ex_shamt), 32'(e.shamt));
      chk("ex_dst", 32'(ex_dst), 32'(e.dst));
      chk("hz_stall", 32'(hz_stall), 32'(e.stall));
      chk("hz_loaduse", 32'(hz_loaduse), 32'(e.loaduse));
`ifdef IDEX_BUBBLE_CNT_EN
      chk("bubble_cnt", bubble_cnt_obs, e.cnt);
`endif
    end
  end

  initial begin
    stim_t s;
    m_ins = '{default: '0}; m_valid = 0; m_cnt = 0;
    // Unchecked start-up cycle to leave X state.
    s = rnd_stim(); s.rst = 1;
    rst = 1; id_valid = 0; id_ctrl = 0; id_pc4 = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0; id_use_rs = 0;
    id_use_rt = 0; ex_stall = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with random ID inputs.
    repeat (2) begin s = rnd_stim(); s.rst = 1; apply(s); end

    // Normal flow: addi $8 then addu $9,$8,$8.
    s = rnd_stim(); s.ctrl = mk_ctrl(SEL_REGDST_RT, 0, 1); s.rt = 8; s.rs = 0; s.use_rs = 1;
    apply(s);
    s = rnd_stim(); s.ctrl = mk_ctrl(SEL_REGDST_RD, 0, 1); s.rs = 8; s.rt = 8; s.rd = 9;
    s.use_rs = 1; s.use_rt = 1; apply(s);

    // Load-use: lw $8, then add reading $8 held for two cycles.
    s = rnd_stim(); s.ctrl = mk_ctrl(SEL_REGDST_RT, 1, 1); s.rt = 8; s.rs = 3; apply(s);
    s = rnd_stim(); s.ctrl = mk_ctrl(SEL_REGDST_RD, 0, 1); s.rs = 8; s.rt = 2; s.rd = 10;
    s.use_rs = 1; s.use_rt = 1; apply(s); apply(s);

    // lw $0 followed by a reader of $0: no hazard.
    s = rnd_stim(); s.ctrl = mk_ctrl(SEL_REGDST_RT, 1, 1); s.rt = 0; s.rs = 4; apply(s);
    s = rnd_stim(); s.ctrl = mk_ctrl(SEL_REGDST_RD, 0, 1); s.rs = 0; s.use_rs = 1; apply(s);

    // EX back-pressure for three cycles, then flush racing a load-use hazard.
    s = rnd_stim(); s.ctrl = mk_ctrl(SEL_REGDST_RD, 0, 1); apply(s);
    repeat (3) begin s = rnd_stim(); s.ex_stall = 1; apply(s); end
    s = rnd_stim(); s.ctrl = mk_ctrl(SEL_REGDST_RT, 1, 1); s.rt = 8; apply(s);
    s = rnd_stim(); s.rs = 8; s.use_rs = 1; s.flush = 1; apply(s);

    // Bubble count: two load-use bubbles, one flush of a valid instruction,
    // one flush with nothing valid anywhere.
    s = rnd_stim(); s.rst = 1; apply(s);
    for (int k = 0; k < 2; k++) begin
      s = rnd_stim(); s.ctrl = mk_ctrl(SEL_REGDST_RT, 1, 1); s.rt = 5'(8 + k); apply(s);
      s = rnd_stim(); s.ctrl = mk_ctrl(SEL_REGDST_RD, 0, 1); s.rt = 5'(8 + k); s.use_rt = 1;
      s.rd = 12; apply(s); apply(s);
    end
    s = rnd_stim(); s.flush = 1; apply(s);
    s = rnd_stim(); s.valid = 0; s.flush = 1; apply(s);
    s = rnd_stim(); s.valid = 0; apply(s);

    // Randomized traffic biased toward register collisions.
    for (int i = 0; i < 2000; i++) begin
      s = rnd_stim();
      s.valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
        s.rd = 5'($urandom_range(0, 3));
      end
      s.use_rs = 1'($urandom); s.use_rt = 1'($urandom);
      s.ex_stall = ($urandom_range(0, 4) == 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.rst = ($urandom_range(0, 49) == 0);
      apply(s);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
